// File: rtl/wic_pkg.sv
// Shared types and limits for the wake-up interrupt controller.
package wic_pkg;

  localparam int WICLINES_MAX = 64;
  localparam int ACKDLY_MAX   = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_ARMED  = 2'd2,
    ST_WAKE   = 2'd3
  } wic_state_e;

endpackage

// File: rtl/wic_controller_if.sv
// Core <-> WIC signal bundle; master is the core side, slave is the WIC.
interface wic_controller_if #(
  parameter int WICLINES = 34
);

  logic                WICENREQ;
  logic                WICENACK;
  logic [WICLINES-1:0] WICMASK;
  logic [WICLINES-1:0] WICMODE;
  logic [WICLINES-1:0] WICINT;
  logic                WICCLEAR;
  logic [WICLINES-1:0] WICSENSE;
  logic [WICLINES-1:0] WICPEND;
  logic                WAKEUP;

  modport master (
    output WICENREQ, WICMASK, WICMODE, WICINT, WICCLEAR,
    input  WICENACK, WICSENSE, WICPEND, WAKEUP
  );

  modport slave (
    input  WICENREQ, WICMASK, WICMODE, WICINT, WICCLEAR,
    output WICENACK, WICSENSE, WICPEND, WAKEUP
  );

endinterface

// File: rtl/wic_line_detect.sv
// One wake-up sense line: captured detect mode, previous sample and sticky pending bit.
module wic_line_detect (
  input  logic clk,
  input  logic rst,
  input  logic intr,
  input  logic sense,
  input  logic load,
  input  logic mode_in,
  input  logic detect_en,
  input  logic clr,
  output logic pend,
  output logic hit
);

  logic mode_p0;
  logic prev_p0;

  // prev_p0 tracks the line in every state so a line already high at arm never looks like an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_p0 <= 1'b0;
      prev_p0 <= 1'b0;
    end else begin
      prev_p0 <= intr;
      if (load) mode_p0 <= mode_in;
    end
  end

  assign hit = detect_en & sense & (mode_p0 ? (intr & ~prev_p0) : intr);

  // set dominates clear so a coincident event is never lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      pend <= 1'b0;
    else if (hit) pend <= 1'b1;
    else if (clr) pend <= 1'b0;
  end

endmodule

// File: rtl/wic_controller.sv
// Wake-up interrupt controller: arms on core request, watches masked lines, raises WAKEUP.
module wic_controller
  import wic_pkg::*;
#(
  parameter int WICLINES = 34,
  parameter int ACKDLY   = 1
) (
  input  logic                    FCLK,
  input  logic                    PORESET,
  wic_controller_if.slave         bus
);

  if (WICLINES < 2 || WICLINES > WICLINES_MAX) begin : g_bad_wiclines
    $error("wic_controller: WICLINES=%0d outside 2..%0d", WICLINES, WICLINES_MAX);
  end
  if (ACKDLY < 0 || ACKDLY > ACKDLY_MAX) begin : g_bad_ackdly
    $error("wic_controller: ACKDLY=%0d outside 0..%0d", ACKDLY, ACKDLY_MAX);
  end

  localparam logic [3:0] ACKDLY_L = 4'(ACKDLY);

  wic_state_e          state;
  wic_state_e          nxt;
  logic [3:0]          cnt;
  logic [3:0]          cnt_d;
  logic [WICLINES-1:0] sense_q;
  logic [WICLINES-1:0] sense_d;
  logic [WICLINES-1:0] hit_vec;
  logic [WICLINES-1:0] pend_vec;
  logic                ack_q;
  logic                ack_d;
  logic                wake_q;
  logic                wake_d;
  logic                arm;
  logic                detect_en;
  logic                any_hit;

  assign arm       = (state == ST_IDLE) & bus.WICENREQ;
  assign detect_en = (state == ST_ARMED) | (state == ST_WAKE);
  assign any_hit   = |hit_vec;

  for (genvar i = 0; i < WICLINES; i++) begin : g_line
    wic_line_detect u_line (
      .clk       (FCLK),
      .rst       (PORESET),
      .intr      (bus.WICINT[i]),
      .sense     (sense_q[i]),
      .load      (arm),
      .mode_in   (bus.WICMODE[i]),
      .detect_en (detect_en),
      .clr       (bus.WICCLEAR | arm),
      .pend      (pend_vec[i]),
      .hit       (hit_vec[i])
    );
  end

  // state and registered outputs
  always_ff @(posedge FCLK or posedge PORESET) begin
    if (PORESET) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      sense_q <= '0;
      ack_q   <= 1'b0;
      wake_q  <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_d;
      sense_q <= sense_d;
      ack_q   <= ack_d;
      wake_q  <= wake_d;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (bus.WICENREQ) nxt = ST_ARMING;
      ST_ARMING: begin
        if (!bus.WICENREQ)     nxt = ST_IDLE;
        else if (cnt == 4'd0)  nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (!bus.WICENREQ)     nxt = ST_IDLE;
        else if (any_hit)      nxt = ST_WAKE;
      end
      ST_WAKE:   if (!bus.WICENREQ) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // outputs are decoded from the next state so they change together with the state flops
  always_comb begin
    ack_d   = (nxt == ST_ARMED) | (nxt == ST_WAKE);
    wake_d  = (nxt == ST_WAKE);
    cnt_d   = cnt;
    sense_d = sense_q;
    if (arm) begin
      cnt_d   = ACKDLY_L;
      sense_d = bus.WICMASK;
    end else if (nxt == ST_IDLE) begin
      cnt_d   = 4'd0;
      sense_d = '0;
    end else if (state == ST_ARMING && cnt != 4'd0) begin
      cnt_d   = cnt - 4'd1;
    end
  end

  assign bus.WICENACK = ack_q;
  assign bus.WAKEUP   = wake_q;
  assign bus.WICSENSE = sense_q;
  assign bus.WICPEND  = pend_vec;

endmodule

// File: tb/tb_wic_controller.sv
// Directed bench for wic_controller with hand-computed expectations.
module tb_wic_controller;

  localparam int N = 34;

  logic FCLK    = 1'b0;
  logic PORESET = 1'b1;

  wic_controller_if #(.WICLINES(N)) bus();

  wic_controller #(.WICLINES(N), .ACKDLY(1)) dut (
    .FCLK    (FCLK),
    .PORESET (PORESET),
    .bus     (bus)
  );

  always #5 FCLK = ~FCLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge FCLK);
    #1;
  endtask

  initial begin
    bus.WICENREQ = 1'b0;
    bus.WICMASK  = '0;
    bus.WICMODE  = '0;
    bus.WICINT   = '0;
    bus.WICCLEAR = 1'b0;

    // reset state
    #12;
    chk("rst_ack",   64'(bus.WICENACK), 64'h0);
    chk("rst_wake",  64'(bus.WAKEUP),   64'h0);
    chk("rst_sense", 64'(bus.WICSENSE), 64'h0);
    chk("rst_pend",  64'(bus.WICPEND),  64'h0);
    tick;
    PORESET = 1'b0;
    tick;
    chk("idle_ack", 64'(bus.WICENACK), 64'h0);

    // arm timing, edge mode on line 5 with line held high before arm
    bus.WICMASK  = 34'h20;
    bus.WICMODE  = 34'h20;
    bus.WICINT   = 34'h20;
    bus.WICENREQ = 1'b1;
    tick;
    chk("arm_e0_sense", 64'(bus.WICSENSE), 64'h20);
    chk("arm_e0_ack",   64'(bus.WICENACK), 64'h0);
    tick;
    chk("arm_e1_ack",   64'(bus.WICENACK), 64'h0);
    tick;
    chk("arm_e2_ack",   64'(bus.WICENACK), 64'h1);
    chk("arm_e2_pend",  64'(bus.WICPEND),  64'h0);
    tick;
    chk("preheld_wake", 64'(bus.WAKEUP),   64'h0);
    chk("preheld_pend", 64'(bus.WICPEND),  64'h0);

    // rising edge on line 5
    bus.WICINT = '0;
    tick;
    bus.WICINT = 34'h20;
    tick;
    chk("edge_pend", 64'(bus.WICPEND),  64'h20);
    chk("edge_wake", 64'(bus.WAKEUP),   64'h1);
    chk("edge_ack",  64'(bus.WICENACK), 64'h1);

    // release from WAKE
    bus.WICENREQ = 1'b0;
    tick;
    chk("rel_ack",   64'(bus.WICENACK), 64'h0);
    chk("rel_wake",  64'(bus.WAKEUP),   64'h0);
    chk("rel_pend",  64'(bus.WICPEND),  64'h20);
    chk("rel_sense", 64'(bus.WICSENSE), 64'h0);
    bus.WICCLEAR = 1'b1;
    tick;
    bus.WICCLEAR = 1'b0;
    chk("rel_clear", 64'(bus.WICPEND),  64'h0);

    // level mode with masking
    bus.WICINT   = '0;
    bus.WICMASK  = 34'h1;
    bus.WICMODE  = '0;
    bus.WICENREQ = 1'b1;
    tick;
    tick;
    tick;
    chk("lvl_armed", 64'(bus.WICENACK), 64'h1);
    bus.WICINT = 34'h2;
    tick;
    chk("lvl_masked_wake", 64'(bus.WAKEUP),  64'h0);
    chk("lvl_masked_pend", 64'(bus.WICPEND), 64'h0);
    bus.WICINT = 34'h3;
    tick;
    chk("lvl_pend", 64'(bus.WICPEND), 64'h1);
    chk("lvl_wake", 64'(bus.WAKEUP),  64'h1);
    bus.WICINT   = '0;
    bus.WICCLEAR = 1'b1;
    tick;
    bus.WICCLEAR = 1'b0;
    chk("clr_stays_wake", 64'(bus.WAKEUP),  64'h1);
    chk("clr_in_wake",    64'(bus.WICPEND), 64'h0);

    // level event present throughout ARMING is caught once ARMED
    bus.WICENREQ = 1'b0;
    tick;
    bus.WICMASK  = 34'h8;
    bus.WICMODE  = '0;
    bus.WICINT   = 34'h8;
    bus.WICENREQ = 1'b1;
    tick;
    tick;
    chk("arming_no_set", 64'(bus.WICPEND), 64'h0);
    tick;
    chk("armed_e2_pend", 64'(bus.WICPEND),  64'h0);
    chk("armed_e2_ack",  64'(bus.WICENACK), 64'h1);
    tick;
    chk("persist_pend", 64'(bus.WICPEND), 64'h8);
    chk("persist_wake", 64'(bus.WAKEUP),  64'h1);

    // clear coincident with a line-3 event
    bus.WICCLEAR = 1'b1;
    tick;
    bus.WICCLEAR = 1'b0;
    chk("collision_pend", 64'(bus.WICPEND), 64'h8);

    // arming clears pending events left over from a previous session
    bus.WICENREQ = 1'b0;
    tick;
    chk("idle_retain", 64'(bus.WICPEND), 64'h8);
    bus.WICINT   = '0;
    bus.WICENREQ = 1'b1;
    tick;
    chk("arm_clears_pend", 64'(bus.WICPEND), 64'h0);
    tick;
    tick;
    bus.WICINT = 34'h8;
    tick;
    chk("rewake", 64'(bus.WAKEUP), 64'h1);

    // asynchronous reset mid-wake
    #2;
    PORESET = 1'b1;
    #1;
    chk("rstw_pend",  64'(bus.WICPEND),  64'h0);
    chk("rstw_wake",  64'(bus.WAKEUP),   64'h0);
    chk("rstw_ack",   64'(bus.WICENACK), 64'h0);
    chk("rstw_sense", 64'(bus.WICSENSE), 64'h0);
    tick;
    PORESET = 1'b0;

    // re-arm after reset, then reset inside ARMING
    tick;
    chk("rearm_sense", 64'(bus.WICSENSE), 64'h8);
    chk("rearm_ack",   64'(bus.WICENACK), 64'h0);
    #2;
    PORESET = 1'b1;
    #1;
    chk("rsta_sense", 64'(bus.WICSENSE), 64'h0);
    chk("rsta_ack",   64'(bus.WICENACK), 64'h0);
    chk("rsta_pend",  64'(bus.WICPEND),  64'h0);
    bus.WICENREQ = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
